// File: rtl/debounce_pkg.sv
// Shared types and default thresholds for the multi-channel debouncer.
// Optional feature macro: DEBOUNCE_AUTO_REPEAT_EN (auto-repeat pulses while held,
// press mode only).
package debounce_pkg;

  typedef enum logic [2:0] {
    ST_LOW   = 3'd0,
    ST_L2H   = 3'd1,
    ST_HIGH  = 3'd2,
    ST_H2L   = 3'd3,
    ST_PULSE = 3'd4
  } db_state_t;

  localparam int DEF_N_CH           = 4;
  localparam int DEF_CNT_W          = 8;
  localparam int DEF_RISE_CLKS      = 25;
  localparam int DEF_FALL_CLKS      = 50;
  localparam int DEF_PULSE_CLKS     = 3;
  localparam int DEF_PULSE_ON_PRESS = 0;
  localparam int DEF_REPEAT_CLKS    = 200;

  // Largest of four thresholds; the counter must be able to hold it.
  function automatic int max4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debouncer channel: 2-flop synchroniser, qualification counter and FSM.
// Exposes its state register on STATE so the one-shot and any checker can be
// decoded from it. Optional macro: DEBOUNCE_AUTO_REPEAT_EN.
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int CNT_W          = DEF_CNT_W,
  parameter int RISE_CLKS      = DEF_RISE_CLKS,
  parameter int FALL_CLKS      = DEF_FALL_CLKS,
  parameter int PULSE_CLKS     = DEF_PULSE_CLKS,
  parameter int PULSE_ON_PRESS = DEF_PULSE_ON_PRESS,
  parameter int REPEAT_CLKS    = DEF_REPEAT_CLKS
) (
  input  logic      CLK,
  input  logic      RST,
  input  logic      BTN,
  output logic      DB_LEVEL,
  output db_state_t STATE
);

  localparam int MAX_THR = max4(RISE_CLKS, FALL_CLKS, PULSE_CLKS, REPEAT_CLKS);
  localparam bit PRESS_MODE = (PULSE_ON_PRESS != 0);

  localparam logic [CNT_W-1:0] RISE_LAST  = CNT_W'(RISE_CLKS - 1);
  localparam logic [CNT_W-1:0] FALL_LAST  = CNT_W'(FALL_CLKS - 1);
  localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_CLKS - 1);
`ifdef DEBOUNCE_AUTO_REPEAT_EN
  localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CLKS - 1);
`endif
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  // The counter stops at each threshold, so it only has to hold the largest one.
  if (MAX_THR > (1 << CNT_W) - 1) begin : g_cnt_w_check
    $error("debounce_channel: CNT_W too small for the largest threshold");
  end

  logic [1:0]       sync;
  logic             s;
  logic [CNT_W-1:0] cnt, cnt_nx;
  db_state_t        state, state_nx;

  assign s = sync[1];

  // Synchroniser, counter and state registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      sync  <= 2'b00;
      cnt   <= '0;
      state <= ST_LOW;
    end else begin
      sync  <= {sync[0], BTN};
      cnt   <= cnt_nx;
      state <= state_nx;
    end
  end

  // Next-state and counter logic; the pulse state ignores the input entirely.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    case (state)
      ST_LOW: begin
        if (s) begin
          cnt_nx   = CNT_ONE;
          state_nx = ST_L2H;
        end else begin
          cnt_nx = '0;
        end
      end
      ST_L2H: begin
        if (!s) begin
          cnt_nx   = '0;
          state_nx = ST_LOW;
        end else if (cnt == RISE_LAST) begin
          cnt_nx   = '0;
          state_nx = PRESS_MODE ? ST_PULSE : ST_HIGH;
        end else begin
          cnt_nx = cnt + CNT_ONE;
        end
      end
      ST_HIGH: begin
        if (!s) begin
          cnt_nx   = CNT_ONE;
          state_nx = ST_H2L;
        end else begin
`ifdef DEBOUNCE_AUTO_REPEAT_EN
          if (PRESS_MODE) begin
            if (cnt == REPEAT_LAST) begin
              cnt_nx   = '0;
              state_nx = ST_PULSE;
            end else begin
              cnt_nx = cnt + CNT_ONE;
            end
          end else begin
            cnt_nx = '0;
          end
`else
          cnt_nx = '0;
`endif
        end
      end
      ST_H2L: begin
        if (s) begin
          cnt_nx   = '0;
          state_nx = ST_HIGH;
        end else if (cnt == FALL_LAST) begin
          cnt_nx   = '0;
          state_nx = PRESS_MODE ? ST_LOW : ST_PULSE;
        end else begin
          cnt_nx = cnt + CNT_ONE;
        end
      end
      ST_PULSE: begin
        if (cnt == PULSE_LAST) begin
          cnt_nx   = '0;
          state_nx = PRESS_MODE ? ST_HIGH : ST_LOW;
        end else begin
          cnt_nx = cnt + CNT_ONE;
        end
      end
      default: begin
        cnt_nx   = '0;
        state_nx = ST_LOW;
      end
    endcase
  end

  // Moore level decode: high while qualified-high, and during a press-mode pulse.
  always_comb begin
    DB_LEVEL = (state == ST_HIGH) || (state == ST_H2L) ||
               ((state == ST_PULSE) && PRESS_MODE);
  end

  assign STATE = state;

endmodule

// File: rtl/debounce_multi_ch.sv
// N-channel debouncer with per-channel one-shot and an OR of all one-shots.
// Optional macro: DEBOUNCE_AUTO_REPEAT_EN (auto-repeat in press mode).
module debounce_multi_ch
  import debounce_pkg::*;
#(
  parameter int N_CH           = DEF_N_CH,
  parameter int CNT_W          = DEF_CNT_W,
  parameter int RISE_CLKS      = DEF_RISE_CLKS,
  parameter int FALL_CLKS      = DEF_FALL_CLKS,
  parameter int PULSE_CLKS     = DEF_PULSE_CLKS,
  parameter int PULSE_ON_PRESS = DEF_PULSE_ON_PRESS,
  parameter int REPEAT_CLKS    = DEF_REPEAT_CLKS
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic [N_CH-1:0] BTN,
  output logic [N_CH-1:0] DB_LEVEL,
  output logic [N_CH-1:0] PULSE,
  output logic            ANY_PULSE
);

  if (N_CH < 1) begin : g_n_ch_check
    $error("debounce_multi_ch: N_CH must be at least 1");
  end

  db_state_t ch_state [N_CH];

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    debounce_channel #(
      .CNT_W          (CNT_W),
      .RISE_CLKS      (RISE_CLKS),
      .FALL_CLKS      (FALL_CLKS),
      .PULSE_CLKS     (PULSE_CLKS),
      .PULSE_ON_PRESS (PULSE_ON_PRESS),
      .REPEAT_CLKS    (REPEAT_CLKS)
    ) u_ch (
      .CLK      (CLK),
      .RST      (RST),
      .BTN      (BTN[i]),
      .DB_LEVEL (DB_LEVEL[i]),
      .STATE    (ch_state[i])
    );

    // One-shot is a registered-state decode, so BTN never reaches it combinationally.
    always_comb begin
      PULSE[i] = (ch_state[i] == ST_PULSE);
    end
  end

  // Any channel pulsing.
  always_comb begin
    ANY_PULSE = |PULSE;
  end

endmodule

// File: doc/debounce_multi_ch.md
Name: debounce_multi_ch

Overview:
- Parametrised N-channel debouncer with a per-channel one-shot; successor to the single-button debounce/one-shot.
- Each channel: 2-flop input synchroniser, independent counter and FSM, a debounced level output and a one-shot pulse output.
- Pulse is selectable to fire on qualified press or on qualified release.
- Sits between board buttons/switches and the RAT I/O input ports, clocked by the 50 MHz RAT clock.

Parameters:
- N_CH, 4, number of independent channels (>=1)
- CNT_W, 8, counter width; must hold max(RISE_CLKS, FALL_CLKS, PULSE_CLKS, REPEAT_CLKS)
- RISE_CLKS, 25, consecutive synchronised-high samples that qualify a press (>=2)
- FALL_CLKS, 50, consecutive synchronised-low samples that qualify a release (>=2)
- PULSE_CLKS, 3, one-shot width in clocks (>=1)
- PULSE_ON_PRESS, 0, 0 = pulse after qualified release (legacy); 1 = pulse after qualified press
- REPEAT_CLKS, 200, auto-repeat period in clocks; used only with AUTO_REPEAT_EN

Ports:
- CLK  input  1  system clock, 50 MHz
- RST  input  1  synchronous, active-high reset
- BTN  input  N_CH  raw asynchronous button inputs
- DB_LEVEL  output  N_CH  debounced level per channel
- PULSE  output  N_CH  one-shot per channel
- ANY_PULSE  output  1  OR-reduction of PULSE

Behaviour:
- Reset (RST=1 at an edge):
  - Synchronisers, counters and states clear to 0 / ST_LOW.
  - DB_LEVEL, PULSE and ANY_PULSE are 0 from the next cycle.
  - Reset mid-pulse truncates the pulse immediately.
- Outputs are Moore-decoded from the state register; there is no combinational path BTN->output. s = synchroniser output.
- ST_LOW:
  - s=1: cnt<=1, go to ST_L2H.
  - Otherwise cnt<=0.
- ST_L2H:
  - s=0: go to ST_LOW, cnt<=0.
  - s=1 and cnt==RISE_CLKS-1: cnt<=0, go to ST_PULSE if PULSE_ON_PRESS, else ST_HIGH.
  - Otherwise cnt++.
- ST_HIGH (DB_LEVEL=1):
  - s=0: cnt<=1, go to ST_H2L.
  - Otherwise cnt<=0.
- ST_H2L (DB_LEVEL=1):
  - s=1: go to ST_HIGH, cnt<=0.
  - s=0 and cnt==FALL_CLKS-1: cnt<=0, go to ST_PULSE if !PULSE_ON_PRESS, else ST_LOW.
  - Otherwise cnt++.
- ST_PULSE:
  - PULSE=1 for exactly PULSE_CLKS cycles; s is ignored during this state.
  - Exit to ST_HIGH when PULSE_ON_PRESS, else ST_LOW.
  - DB_LEVEL=1 during the pulse in press mode, 0 in release mode.
  - If s already differs from the exit state's level, the following state begins qualification on the next cycle; no event is lost.
- Latency:
  - Edge k is the first edge capturing BTN=1.
  - DB_LEVEL (release mode) or PULSE (press mode) rises after edge k+RISE_CLKS+1.
  - Release is symmetric with FALL_CLKS.
- Channels are fully independent; simultaneous events on any channels are each handled.
- cnt never wraps: thresholds stop counting before CNT_W overflow; CNT_W is checked with a static assertion.

Optional Feature:
- Macro: DEBOUNCE_AUTO_REPEAT_EN.
- Defined, and PULSE_ON_PRESS=1:
  - In ST_HIGH with s=1, cnt increments.
  - At cnt==REPEAT_CLKS-1, go to ST_PULSE (returning to ST_HIGH), cnt<=0.
  - Result: repeated pulses every REPEAT_CLKS+PULSE_CLKS clocks while held.
- Not defined, or PULSE_ON_PRESS=0: ST_HIGH holds cnt at 0; exactly one pulse per press/release cycle; REPEAT_CLKS is ignored.

Decomposition:
- Package debounce_pkg: state enum typedef (ST_LOW, ST_L2H, ST_HIGH, ST_H2L, ST_PULSE) and default threshold constants.
- Sub-module debounce_channel: synchroniser, counter and FSM for one channel.
- Top generates N_CH instances of debounce_channel and the ANY_PULSE OR.

Test Plan:
- Reset/idle: RST=1 for 3 clocks with BTN=all 1s -> all outputs 0; after release, BTN ch0 held high -> DB_LEVEL[0] rises after edge k+26; no PULSE in release mode.
- Bounce rejection: ch1 toggles high 10 clocks / low 2 clocks ×5, then stable high 30 -> DB_LEVEL[1] rises once, 26 edges after the final stable rise; no glitches.
- Release one-shot (PULSE_ON_PRESS=0): ch2 press 40, release stable 60 -> PULSE[2]=1 for exactly 3 clocks starting edge k_rel+51; ANY_PULSE matches.
- Press mode (PULSE_ON_PRESS=1, RISE_CLKS=4): press -> PULSE high 3 clocks after edge k+5 with DB_LEVEL=1; BTN released during pulse -> pulse completes, then H2L starts.
- Concurrency/reset: ch0 and ch3 released on the same clock -> both pulse on the same cycles; RST asserted in the 2nd pulse cycle -> PULSE=0 next cycle, no resumption.
- With DEBOUNCE_AUTO_REPEAT_EN, REPEAT_CLKS=20, press mode, 100-clock hold -> initial pulse plus repeats spaced 23 clocks; without the macro -> single pulse.
